phys_reg_free_list: RTL and testbench

Free-list controller for the physical register file. It holds the tags of all unallocated physical registers in a circular buffer and hands up to WRITE_PORTS of them per cycle to rename. It reclaims up to WRITE_PORTS tags per cycle from commit. It sits between rename/commit and the register-state tracker: every tag it grants is the tag rename marks allocated, and every tag it reclaims is one commit has released.

---
 rtl/phys_reg_free_list_if.sv | 32 +++
 rtl/phys_reg_free_list.sv | 182 ++++++++++++++++++
 tb/tb_phys_reg_free_list.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/phys_reg_free_list_if.sv
// Bundle between rename/commit and the physical register free list.
// Carries allocation request/grant/tags, reclaim strobes/tags and status.
// master: rename/commit side; slave: free list.
interface phys_reg_free_list_if #(
  parameter int PHYS_COUNT  = 128,
  parameter int ARCH_COUNT  = 32,
  parameter int WRITE_PORTS = 4
);
  localparam int DEPTH      = PHYS_COUNT - ARCH_COUNT;
  localparam int ADDR_WIDTH = $clog2(PHYS_COUNT);
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

  logic [WRITE_PORTS-1:0]                 alloc_req;
  logic                                   alloc_gnt;
  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] alloc_tag;
  logic [WRITE_PORTS-1:0]                 reclaim_valid;
  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] reclaim_tag;
  logic                                   init_done;
  logic [CNT_WIDTH-1:0]                   free_count;
  logic                                   overflow_err;
  logic                                   dbl_free_err;

  modport master (
    output alloc_req, reclaim_valid, reclaim_tag,
    input  alloc_gnt, alloc_tag, init_done, free_count, overflow_err, dbl_free_err
  );

  modport slave (
    input  alloc_req, reclaim_valid, reclaim_tag,
    output alloc_gnt, alloc_tag, init_done, free_count, overflow_err, dbl_free_err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: grants up to WRITE_PORTS per cycle, reclaims up to WRITE_PORTS.
// Latency: grant/tags combinational from registered state; reclaimed tags allocatable the next cycle.
// Backpressure: all-or-nothing grant when enough tags are free; reclaims beyond capacity dropped (sticky overflow_err).
//
// Ports: clk, sync_rst_n (synchronous, active-low), fl (slave modport: alloc_req/alloc_gnt/alloc_tag,
//        reclaim_valid/reclaim_tag, init_done, free_count, overflow_err, dbl_free_err).
// Optional macro FREE_LIST_DOUBLE_FREE_CHECK_EN adds the in_list vector and double-free rejection;
// without it every valid reclaim is accepted and dbl_free_err is tied 0.
module phys_reg_free_list #(
  parameter int PHYS_COUNT  = 128,
  parameter int ARCH_COUNT  = 32,
  parameter int WRITE_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 sync_rst_n,
  phys_reg_free_list_if.slave  fl
);
  localparam int DEPTH      = PHYS_COUNT - ARCH_COUNT;
  localparam int ADDR_WIDTH = $clog2(PHYS_COUNT);
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1);
  localparam int PTR_WIDTH  = $clog2(DEPTH);
  localparam int LN_WIDTH   = $clog2(WRITE_PORTS + 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 state_q;
  logic                   init_done_q;
  logic [PTR_WIDTH-1:0]   head_q, tail_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic                   ovf_q;
  logic [ADDR_WIDTH-1:0]  buf_q [DEPTH];

  logic [LN_WIDTH-1:0]    n_req;
  logic                   gnt;
  logic [CNT_WIDTH-1:0]   n_gnt;
  logic [CNT_WIDTH-1:0]   space;
  logic [LN_WIDTH-1:0]    m_acc;
  logic                   ovf_set;
  logic [WRITE_PORTS-1:0] rej;
  logic [WRITE_PORTS-1:0] wr_en;
  logic [PTR_WIDTH-1:0]   wr_idx [WRITE_PORTS];
  logic [ADDR_WIDTH-1:0]  tag_w  [WRITE_PORTS];

  // Pointer advance with explicit wrap; k never exceeds WRITE_PORTS, so one subtract suffices.
  function automatic logic [PTR_WIDTH-1:0] ptr_add(input logic [PTR_WIDTH-1:0] p,
                                                   input logic [LN_WIDTH-1:0]  k);
    logic [PTR_WIDTH:0] s;
    s = {1'b0, p} + {{(PTR_WIDTH + 1 - LN_WIDTH){1'b0}}, k};
    if (s >= (PTR_WIDTH + 1)'(DEPTH)) s = s - (PTR_WIDTH + 1)'(DEPTH);
    return s[PTR_WIDTH-1:0];
  endfunction

  // Allocation: the k-th requesting lane reads the k-th entry past head.
  always_comb begin
    n_req = '0;
    for (int l = 0; l < WRITE_PORTS; l++) begin
      tag_w[l] = buf_q[ptr_add(head_q, n_req)];
      n_req    = n_req + LN_WIDTH'(fl.alloc_req[l]);
    end
  end

  assign gnt   = init_done_q && (n_req != '0) && (CNT_WIDTH'(n_req) <= count_q);
  assign n_gnt = gnt ? CNT_WIDTH'(n_req) : '0;
  // Room left once this cycle's grant has been taken out.
  assign space = CNT_WIDTH'(DEPTH) - (count_q - n_gnt);

  always_comb begin
    for (int l = 0; l < WRITE_PORTS; l++) fl.alloc_tag[l] = tag_w[l];
  end

  // Reclaim: surviving lanes pack contiguously from tail, lowest lane first, until the buffer is full.
  always_comb begin
    m_acc   = '0;
    ovf_set = 1'b0;
    for (int l = 0; l < WRITE_PORTS; l++) begin
      wr_en[l]  = 1'b0;
      wr_idx[l] = ptr_add(tail_q, m_acc);
      if (fl.reclaim_valid[l] && !rej[l] && (state_q == S_RUN)) begin
        if (CNT_WIDTH'(m_acc) < space) begin
          wr_en[l] = 1'b1;
          m_acc    = m_acc + LN_WIDTH'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state_q     <= S_INIT;
      init_done_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          tail_q  <= ptr_add(tail_q, LN_WIDTH'(1));
          count_q <= count_q + CNT_WIDTH'(1);
          if (tail_q == PTR_WIDTH'(DEPTH - 1)) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (gnt) head_q <= ptr_add(head_q, n_req);
          tail_q  <= ptr_add(tail_q, m_acc);
          count_q <= count_q - n_gnt + CNT_WIDTH'(m_acc);
        end
        default: state_q <= S_INIT;
      endcase
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  // Storage is not reset; INIT rewrites every entry before it can be read.
  always_ff @(posedge clk) begin
    if (sync_rst_n) begin
      if (state_q == S_INIT) begin
        buf_q[tail_q] <= ADDR_WIDTH'(ARCH_COUNT) + ADDR_WIDTH'(tail_q);
      end else begin
        for (int l = 0; l < WRITE_PORTS; l++) begin
          if (wr_en[l]) buf_q[wr_idx[l]] <= fl.reclaim_tag[l];
        end
      end
    end
  end

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  logic [PHYS_COUNT-1:0] in_list_q;
  logic                  dbl_q;
  logic                  dbl_set;

  // A lane is rejected if its tag is already free, is an arch tag during INIT,
  // or repeats a lower valid lane's tag this cycle.
  always_comb begin
    rej = '0;
    for (int l = 0; l < WRITE_PORTS; l++) begin
      if (fl.reclaim_valid[l]) begin
        if (in_list_q[fl.reclaim_tag[l]]) rej[l] = 1'b1;
        if ((state_q == S_INIT) && (fl.reclaim_tag[l] < ADDR_WIDTH'(ARCH_COUNT))) rej[l] = 1'b1;
        for (int p = 0; p < l; p++) begin
          if (fl.reclaim_valid[p] && (fl.reclaim_tag[p] == fl.reclaim_tag[l])) rej[l] = 1'b1;
        end
      end
    end
  end

  assign dbl_set = |rej;

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      in_list_q <= '0;
      dbl_q     <= 1'b0;
    end else begin
      if (state_q == S_INIT) begin
        in_list_q[ADDR_WIDTH'(ARCH_COUNT) + ADDR_WIDTH'(tail_q)] <= 1'b1;
      end else begin
        for (int l = 0; l < WRITE_PORTS; l++) begin
          if (gnt && fl.alloc_req[l]) in_list_q[tag_w[l]] <= 1'b0;
        end
        for (int l = 0; l < WRITE_PORTS; l++) begin
          if (wr_en[l]) in_list_q[fl.reclaim_tag[l]] <= 1'b1;
        end
      end
      if (dbl_set) dbl_q <= 1'b1;
    end
  end

  assign fl.dbl_free_err = dbl_q;
`else
  assign rej             = '0;
  assign fl.dbl_free_err = 1'b0;
`endif

  assign fl.alloc_gnt    = gnt;
  assign fl.init_done    = init_done_q;
  assign fl.free_count   = count_q;
  assign fl.overflow_err = ovf_q;
endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;
  localparam int PHYS  = 128;
  localparam int ARCH  = 32;
  localparam int WP    = 4;
  localparam int DEPTH = PHYS - ARCH;

  logic clk = 1'b0;
  logic sync_rst_n = 1'b0;
  always #5 clk = ~clk;

  phys_reg_free_list_if #(.PHYS_COUNT(PHYS), .ARCH_COUNT(ARCH), .WRITE_PORTS(WP)) fl_if ();

  phys_reg_free_list #(.PHYS_COUNT(PHYS), .ARCH_COUNT(ARCH), .WRITE_PORTS(WP)) dut (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .fl         (fl_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the free list as an ordered queue of tags, plus the set of tags held by rename.
  int q[$];
  int held[$];
  int init_cnt;
  bit init_m, ovf_m, dbl_m;

  logic [WP-1:0] req, vld;
  logic [6:0]    rtag [WP];

  logic          obs_gnt, obs_init, obs_ovf, obs_dbl;
  logic [6:0]    obs_tag [WP];
  int            obs_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit in_queue(input int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic take_held(input int t);
    foreach (held[i]) if (held[i] == t) begin held.delete(i); return; end
  endtask

  task automatic model_reset();
    q.delete();
    held.delete();
    for (int i = 0; i < ARCH; i++) held.push_back(i);
    init_cnt = 0;
    init_m = 0; ovf_m = 0; dbl_m = 0;
  endtask

  task automatic run_cycle();
    int n, k;
    bit g;
    bit rej [WP];
    fl_if.alloc_req     = req;
    fl_if.reclaim_valid = vld;
    for (int l = 0; l < WP; l++) fl_if.reclaim_tag[l] = rtag[l];
    #4;
    n = $countones(req);
    g = init_m && (n != 0) && (n <= q.size());
    obs_gnt  = fl_if.alloc_gnt;
    obs_init = fl_if.init_done;
    obs_ovf  = fl_if.overflow_err;
    obs_dbl  = fl_if.dbl_free_err;
    obs_cnt  = int'(fl_if.free_count);
    for (int l = 0; l < WP; l++) obs_tag[l] = fl_if.alloc_tag[l];
    check_eq("alloc_gnt", 32'(obs_gnt), 32'(g));
    check_eq("init_done", 32'(obs_init), 32'(init_m));
    check_eq("free_count", 32'(obs_cnt), 32'(q.size()));
    check_eq("overflow_err", 32'(obs_ovf), 32'(ovf_m));
    check_eq("dbl_free_err", 32'(obs_dbl), 32'(dbl_m));
    if (g) begin
      k = 0;
      for (int l = 0; l < WP; l++) if (req[l]) begin
        check_eq("alloc_tag", 32'(obs_tag[l]), 32'(q[k]));
        k++;
      end
    end
    for (int l = 0; l < WP; l++) rej[l] = 1'b0;
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    for (int l = 0; l < WP; l++) if (vld[l]) begin
      if (in_queue(int'(rtag[l]))) rej[l] = 1'b1;
      if (!init_m && (rtag[l] < 7'(ARCH))) rej[l] = 1'b1;
      for (int p = 0; p < l; p++) if (vld[p] && (rtag[p] == rtag[l])) rej[l] = 1'b1;
    end
`endif
    if (!sync_rst_n) begin
      model_reset();
    end else if (!init_m) begin
      for (int l = 0; l < WP; l++) if (vld[l] && rej[l]) dbl_m = 1'b1;
      q.push_back(ARCH + init_cnt);
      init_cnt++;
      if (init_cnt == DEPTH) init_m = 1'b1;
    end else begin
      if (g) repeat (n) held.push_back(q.pop_front());
      for (int l = 0; l < WP; l++) if (vld[l]) begin
        if (rej[l]) dbl_m = 1'b1;
        else if (q.size() < DEPTH) q.push_back(int'(rtag[l]));
        else ovf_m = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int c);
    req = '0; vld = '0;
    repeat (c) run_cycle();
  endtask

  task automatic do_reset();
    sync_rst_n = 1'b0;
    idle(2);
    sync_rst_n = 1'b1;
  endtask

  task automatic random_reclaims();
    int idx;
    vld = '0;
    for (int l = 0; l < WP; l++) begin
      rtag[l] = 7'($urandom_range(0, PHYS - 1));
      if (init_m && ($urandom_range(0, 2) == 0)) begin
        if ($urandom_range(0, 15) == 0) begin
          vld[l] = 1'b1;
        end else if (held.size() > 0) begin
          idx = $urandom_range(0, held.size() - 1);
          rtag[l] = 7'(held[idx]);
          held.delete(idx);
          vld[l] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    req = '0; vld = '0;
    for (int l = 0; l < WP; l++) rtag[l] = '0;
    fl_if.alloc_req = '0; fl_if.reclaim_valid = '0;
    for (int l = 0; l < WP; l++) fl_if.reclaim_tag[l] = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Init timing and first full-width allocation.
    do_reset();
    idle(DEPTH - 1);
    idle(1);
    check_eq("init_low_at_95", 32'(obs_init), 32'd0);
    req = 4'hF; run_cycle();
    check_eq("tp1_count", 32'(obs_cnt), 32'd96);
    check_eq("tp1_gnt", 32'(obs_gnt), 32'd1);
    for (int l = 0; l < WP; l++) check_eq("tp1_tag", 32'(obs_tag[l]), 32'(32 + l));

    // Sparse request mask, then drain to the empty boundary.
    do_reset();
    idle(DEPTH);
    req = 4'b1010; run_cycle();
    check_eq("tp2_gnt", 32'(obs_gnt), 32'd1);
    check_eq("tp2_lane1", 32'(obs_tag[1]), 32'd32);
    check_eq("tp2_lane3", 32'(obs_tag[3]), 32'd33);
    idle(1);
    check_eq("tp2_count", 32'(obs_cnt), 32'd94);
    req = 4'hF; repeat (23) run_cycle();
    req = 4'b0111; run_cycle();
    check_eq("tp3_deny", 32'(obs_gnt), 32'd0);
    idle(1);
    check_eq("tp3_count2", 32'(obs_cnt), 32'd2);
    req = 4'b0011; run_cycle();
    check_eq("tp3_gnt", 32'(obs_gnt), 32'd1);
    idle(1);
    check_eq("tp3_count0", 32'(obs_cnt), 32'd0);

    // No same-cycle bypass of reclaimed tags.
    take_held(40); take_held(41);
    req = 4'b0001; vld = 4'b0011; rtag[0] = 7'd40; rtag[1] = 7'd41; run_cycle();
    check_eq("tp4_nobypass", 32'(obs_gnt), 32'd0);
    vld = '0; run_cycle();
    check_eq("tp4_gnt", 32'(obs_gnt), 32'd1);
    check_eq("tp4_tag", 32'(obs_tag[0]), 32'd40);

    // Overflow at full, then reset mid-stream.
    do_reset();
    idle(DEPTH);
    take_held(5);
    vld = 4'b0001; rtag[0] = 7'd5; run_cycle();
    idle(1);
    check_eq("tp5_ovf", 32'(obs_ovf), 32'd1);
    check_eq("tp5_count", 32'(obs_cnt), 32'd96);
    sync_rst_n = 1'b0; idle(1); sync_rst_n = 1'b1;
    idle(1);
    check_eq("tp5_ovf_clr", 32'(obs_ovf), 32'd0);
    idle(DEPTH);

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
    // Double free of a tag that is already free, and duplicate lanes.
    do_reset();
    idle(DEPTH);
    req = 4'hF; repeat (5) run_cycle();
    req = '0; vld = 4'b0001; rtag[0] = 7'd60; run_cycle();
    vld = '0; run_cycle();
    check_eq("tp6_dbl", 32'(obs_dbl), 32'd1);
    check_eq("tp6_count", 32'(obs_cnt), 32'd76);
    do_reset();
    idle(DEPTH);
    req = 4'hF; repeat (5) run_cycle();
    take_held(50);
    req = '0; vld = 4'b0011; rtag[0] = 7'd50; rtag[1] = 7'd50; run_cycle();
    vld = '0; run_cycle();
    check_eq("tp6_dup_dbl", 32'(obs_dbl), 32'd1);
    check_eq("tp6_dup_count", 32'(obs_cnt), 32'd77);
`endif

    // Randomised traffic against the queue model, with occasional resets.
    do_reset();
    idle(DEPTH);
    for (int c = 0; c < 3000; c++) begin
      sync_rst_n = ($urandom_range(0, 999) != 0);
      req = 4'($urandom_range(0, 15));
      random_reclaims();
      run_cycle();
    end
    sync_rst_n = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
